// File: rtl/led_seq_ctrl.sv
// led_seq_ctrl: step-table sequencer and PWM gating for the four user LEDs.
// An 8-entry table holds an LED pattern and a brightness level per step.
// In RUN the step advances automatically after a speed-dependent number of
// PWM frames. Button inputs are one-cycle pulses from the board debouncers.
module led_seq_ctrl #(
    parameter int unsigned PWM_PERIOD   = 1000000,
    parameter int unsigned DWELL_FRAMES = 50
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start_p,
    input  logic       stop_p,
    input  logic       next_p,
    input  logic       prev_p,
    input  logic       fast_p,
    input  logic       slow_p,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [3:0] wr_pat,
    input  logic [2:0] wr_lvl,
    output logic [3:0] led,
    output logic [2:0] step,
    output logic [1:0] state,
    output logic [1:0] speed
);

    localparam int unsigned PWM_W   = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
    localparam int unsigned DW_W    = $clog2(DWELL_FRAMES + 1);
    localparam int unsigned QUARTER = PWM_PERIOD / 4;
    localparam logic [PWM_W-1:0] PWM_LAST = PWM_W'(PWM_PERIOD - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10
    } state_t;

    // Levels above full brightness are stored as full brightness.
    function automatic logic [2:0] clamp_lvl(input logic [2:0] lvl);
        logic [2:0] res;
        if (lvl > 3'd4) begin
            res = 3'd4;
        end else begin
            res = lvl;
        end
        return res;
    endfunction

    // Number of pwm_cnt values per frame during which a level is lit.
    function automatic logic [31:0] duty_limit(input logic [2:0] lvl);
        logic [31:0] res;
        case (lvl)
            3'd0:    res = 32'd0;
            3'd1:    res = 32'(QUARTER);
            3'd2:    res = 32'(QUARTER * 2);
            3'd3:    res = 32'(QUARTER * 3);
            3'd4:    res = 32'(PWM_PERIOD);
            default: res = 32'(PWM_PERIOD);
        endcase
        return res;
    endfunction

    // Frames per step for a given speed, never below one.
    function automatic logic [DW_W-1:0] dwell_limit(input logic [1:0] spd);
        logic [31:0] tmp;
        tmp = 32'(DWELL_FRAMES) >> spd;
        if (tmp == 32'd0) begin
            tmp = 32'd1;
        end else begin
            tmp = tmp;
        end
        return DW_W'(tmp);
    endfunction

    // Power-up pattern: a light walking out to LED 3 and back.
    function automatic logic [3:0] pat_reset(input int unsigned idx);
        logic [3:0] res;
        case (idx)
            0:       res = 4'b0001;
            1:       res = 4'b0010;
            2:       res = 4'b0100;
            3:       res = 4'b1000;
            4:       res = 4'b1000;
            5:       res = 4'b0100;
            6:       res = 4'b0010;
            7:       res = 4'b0001;
            default: res = 4'b0000;
        endcase
        return res;
    endfunction

    state_t           state_q, state_d;
    logic [2:0]       step_q, step_d;
    logic [1:0]       speed_q, speed_d;
    logic [3:0]       led_q, led_d;
    logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [DW_W-1:0]  dwell_q, dwell_d;
    logic [3:0]       tbl_pat_q [8];
    logic [3:0]       tbl_pat_d [8];
    logic [2:0]       tbl_lvl_q [8];
    logic [2:0]       tbl_lvl_d [8];

    logic             frame_end_s;
    logic             pwm_on_s;
    logic [DW_W-1:0]  dwell_lim_s;

    assign frame_end_s = (pwm_cnt_q == PWM_LAST);
    assign dwell_lim_s = dwell_limit(speed_q);
    assign pwm_on_s    = (32'(pwm_cnt_q) < duty_limit(tbl_lvl_q[step_q]));

    // Free-running PWM frame counter, runs in every state.
    always_comb begin
        pwm_cnt_d = pwm_cnt_q;
        if (frame_end_s) begin
            pwm_cnt_d = '0;
        end else begin
            pwm_cnt_d = pwm_cnt_q + PWM_W'(1);
        end
    end

    // Table write port; new contents become visible on the following cycle.
    always_comb begin
        tbl_pat_d = tbl_pat_q;
        tbl_lvl_d = tbl_lvl_q;
        if (wr_en) begin
            tbl_pat_d[wr_addr] = wr_pat;
            tbl_lvl_d[wr_addr] = clamp_lvl(wr_lvl);
        end else begin
            tbl_pat_d = tbl_pat_q;
            tbl_lvl_d = tbl_lvl_q;
        end
    end

    // Sequencer FSM: run/pause/idle control, manual stepping and auto-advance.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        dwell_d = dwell_q;
        if (stop_p) begin
            state_d = ST_IDLE;
            step_d  = 3'd0;
            dwell_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // Stepping is ignored here; only a start does anything.
                    if (start_p) begin
                        state_d = ST_RUN;
                        step_d  = 3'd0;
                        dwell_d = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_RUN, ST_PAUSE: begin
                    if (start_p) begin
                        state_d = (state_q == ST_RUN) ? ST_PAUSE : ST_RUN;
                    end else begin
                        state_d = state_q;
                    end
                    // A manual step replaces any auto-advance in the same cycle;
                    // opposing steps cancel and leave step/dwell untouched.
                    if (next_p && prev_p) begin
                        step_d  = step_q;
                        dwell_d = dwell_q;
                    end else if (next_p) begin
                        step_d  = step_q + 3'd1;
                        dwell_d = '0;
                    end else if (prev_p) begin
                        step_d  = step_q - 3'd1;
                        dwell_d = '0;
                    end else if ((state_q == ST_RUN) && frame_end_s) begin
                        // ">=" lets a speed-up mid-step advance at the next frame end.
                        if (dwell_q >= (dwell_lim_s - DW_W'(1))) begin
                            step_d  = step_q + 3'd1;
                            dwell_d = '0;
                        end else begin
                            dwell_d = dwell_q + DW_W'(1);
                        end
                    end else begin
                        step_d  = step_q;
                        dwell_d = dwell_q;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    step_d  = 3'd0;
                    dwell_d = '0;
                end
            endcase
        end
    end

    // Saturating speed selector; simultaneous fast and slow cancel.
    always_comb begin
        speed_d = speed_q;
        if (fast_p && !slow_p && (speed_q != 2'd3)) begin
            speed_d = speed_q + 2'd1;
        end else if (slow_p && !fast_p && (speed_q != 2'd0)) begin
            speed_d = speed_q - 2'd1;
        end else begin
            speed_d = speed_q;
        end
    end

    // LED gating: current step's pattern while lit and not idle.
    always_comb begin
        led_d = 4'b0000;
        if ((state_q != ST_IDLE) && pwm_on_s) begin
            led_d = tbl_pat_q[step_q];
        end else begin
            led_d = 4'b0000;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            step_q    <= 3'd0;
            speed_q   <= 2'd0;
            led_q     <= 4'b0000;
            pwm_cnt_q <= '0;
            dwell_q   <= '0;
            for (int i = 0; i < 8; i++) begin
                tbl_pat_q[i] <= pat_reset(i);
                tbl_lvl_q[i] <= 3'd4;
            end
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            speed_q   <= speed_d;
            led_q     <= led_d;
            pwm_cnt_q <= pwm_cnt_d;
            dwell_q   <= dwell_d;
            tbl_pat_q <= tbl_pat_d;
            tbl_lvl_q <= tbl_lvl_d;
        end
    end

    assign led   = led_q;
    assign step  = step_q;
    assign state = state_q;
    assign speed = speed_q;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Self-checking bench for led_seq_ctrl with PWM_PERIOD=8, DWELL_FRAMES=8.
// A behavioural model predicts every registered output; each predicted value is
// queued before the clock edge and popped/compared after it. Scenario tasks add
// directed checks against hand-derived constants.
module tb_led_seq_ctrl;

    localparam int PP = 8;
    localparam int DF = 8;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start_p = 1'b0, stop_p = 1'b0, next_p = 1'b0, prev_p = 1'b0;
    logic       fast_p = 1'b0, slow_p = 1'b0, wr_en = 1'b0;
    logic [2:0] wr_addr = 3'd0;
    logic [3:0] wr_pat = 4'd0;
    logic [2:0] wr_lvl = 3'd0;
    logic [3:0] led;
    logic [2:0] step;
    logic [1:0] state;
    logic [1:0] speed;

    led_seq_ctrl #(.PWM_PERIOD(PP), .DWELL_FRAMES(DF)) dut (
        .clk(clk), .reset_n(reset_n),
        .start_p(start_p), .stop_p(stop_p), .next_p(next_p), .prev_p(prev_p),
        .fast_p(fast_p), .slow_p(slow_p),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_pat(wr_pat), .wr_lvl(wr_lvl),
        .led(led), .step(step), .state(state), .speed(speed)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] st;
        logic [2:0] sp;
        logic [1:0] spd;
        logic [3:0] led;
    } exp_t;

    exp_t exp_q[$];
    int tests_run = 0;
    int tests_failed = 0;

    int m_state, m_step, m_speed, m_dwell, m_pwm, m_led;
    int m_pat[8];
    int m_lvl[8];

    task automatic model_reset();
        m_state = 0; m_step = 0; m_speed = 0; m_dwell = 0; m_pwm = 0; m_led = 0;
        m_pat = '{1, 2, 4, 8, 8, 4, 2, 1};
        for (int i = 0; i < 8; i++) m_lvl[i] = 4;
    endtask

    // Predict the effect of the coming clock edge from the current inputs.
    task automatic model_edge();
        int n_state, n_step, n_dwell, d, mv, led_new;
        exp_t e;
        led_new = (m_state != 0 && m_pwm < m_lvl[m_step] * (PP / 4)) ? m_pat[m_step] : 0;
        n_state = m_state; n_step = m_step; n_dwell = m_dwell;
        d = DF >> m_speed;
        if (d < 1) d = 1;
        mv = 0;
        if (next_p && !prev_p) mv = 1;
        else if (prev_p && !next_p) mv = -1;
        if (stop_p) begin
            n_state = 0; n_step = 0; n_dwell = 0;
        end else if (m_state == 0) begin
            if (start_p) begin n_state = 1; n_step = 0; n_dwell = 0; end
        end else begin
            if (start_p) n_state = (m_state == 1) ? 2 : 1;
            if (next_p && prev_p) begin
                n_step = m_step;
            end else if (mv != 0) begin
                n_step = (m_step + mv + 8) % 8; n_dwell = 0;
            end else if (m_state == 1 && m_pwm == PP - 1) begin
                if (m_dwell >= d - 1) begin n_step = (m_step + 1) % 8; n_dwell = 0; end
                else n_dwell = m_dwell + 1;
            end
        end
        if (fast_p && !slow_p && m_speed < 3) m_speed = m_speed + 1;
        else if (slow_p && !fast_p && m_speed > 0) m_speed = m_speed - 1;
        if (wr_en) begin
            m_pat[wr_addr] = int'(wr_pat);
            m_lvl[wr_addr] = (wr_lvl > 3'd4) ? 4 : int'(wr_lvl);
        end
        m_pwm = (m_pwm + 1) % PP;
        m_state = n_state; m_step = n_step; m_dwell = n_dwell; m_led = led_new;
        e.st = 2'(m_state); e.sp = 3'(m_step); e.spd = 2'(m_speed); e.led = 4'(m_led);
        exp_q.push_back(e);
    endtask

    // One clock: queue the prediction, clock, pop and compare, then drop pulses.
    task automatic tick();
        exp_t e;
        model_edge();
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        tests_run++;
        if (state !== e.st) begin tests_failed++; $display("FAIL sb_state t=%0t got %b exp %b", $time, state, e.st); end
        tests_run++;
        if (step !== e.sp) begin tests_failed++; $display("FAIL sb_step t=%0t got %0d exp %0d", $time, step, e.sp); end
        tests_run++;
        if (speed !== e.spd) begin tests_failed++; $display("FAIL sb_speed t=%0t got %0d exp %0d", $time, speed, e.spd); end
        tests_run++;
        if (led !== e.led) begin tests_failed++; $display("FAIL sb_led t=%0t got %b exp %b", $time, led, e.led); end
        start_p = 1'b0; stop_p = 1'b0; next_p = 1'b0; prev_p = 1'b0;
        fast_p = 1'b0; slow_p = 1'b0; wr_en = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        tests_run++;
        if ({led, step, state, speed} !== 11'd0) begin
            tests_failed++; $display("FAIL reset_outputs got %b exp 0", {led, step, state, speed});
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
        tick();
    endtask

    task automatic test_start();
        int c;
        start_p = 1'b1; tick();
        tests_run++;
        if (state !== 2'b01 || step !== 3'd0) begin
            tests_failed++; $display("FAIL start_run got state %b step %0d exp 01/0", state, step);
        end
        c = 0;
        for (int i = 0; i < 8; i++) begin tick(); if (led === 4'b0001) c++; end
        tests_run++;
        if (c != 8) begin tests_failed++; $display("FAIL start_full_on got %0d exp 8", c); end
        for (int i = 0; i < 48; i++) tick();
        tests_run++;
        if (step !== 3'd0) begin tests_failed++; $display("FAIL dwell_early got %0d exp 0", step); end
        for (int i = 0; i < 8; i++) tick();
        tests_run++;
        if (step !== 3'd1) begin tests_failed++; $display("FAIL dwell_advance got %0d exp 1", step); end
    endtask

    task automatic test_duty();
        int c;
        wr_en = 1'b1; wr_addr = 3'd0; wr_pat = 4'b0001; wr_lvl = 3'd1; tick();
        stop_p = 1'b1; tick();
        start_p = 1'b1; tick();
        c = 0;
        for (int i = 0; i < 8; i++) begin tick(); if (led === 4'b0001) c++; end
        tests_run++;
        if (c != 2) begin tests_failed++; $display("FAIL duty_lvl1 got %0d exp 2", c); end
        wr_en = 1'b1; wr_addr = 3'd0; wr_pat = 4'b0001; wr_lvl = 3'd7; tick();
        c = 0;
        for (int i = 0; i < 8; i++) begin tick(); if (led === 4'b0001) c++; end
        tests_run++;
        if (c != 8) begin tests_failed++; $display("FAIL duty_clamp got %0d exp 8", c); end
    endtask

    task automatic test_wrap_manual();
        int c;
        prev_p = 1'b1; tick();
        tests_run++;
        if (step !== 3'd7) begin tests_failed++; $display("FAIL prev_wrap got %0d exp 7", step); end
        wr_en = 1'b1; wr_addr = 3'd7; wr_pat = 4'b0001; wr_lvl = 3'd2; tick();
        start_p = 1'b1; tick();
        tests_run++;
        if (state !== 2'b10) begin tests_failed++; $display("FAIL pause got %b exp 10", state); end
        next_p = 1'b1; tick();
        tests_run++;
        if (step !== 3'd0) begin tests_failed++; $display("FAIL next_wrap got %0d exp 0", step); end
        prev_p = 1'b1; tick();
        tests_run++;
        if (step !== 3'd7) begin tests_failed++; $display("FAIL prev_back got %0d exp 7", step); end
        next_p = 1'b1; prev_p = 1'b1; tick();
        tests_run++;
        if (step !== 3'd7) begin tests_failed++; $display("FAIL next_prev_cancel got %0d exp 7", step); end
        c = 0;
        for (int i = 0; i < 8; i++) begin tick(); if (led === 4'b0001) c++; end
        tests_run++;
        if (c != 4 || state !== 2'b10) begin
            tests_failed++; $display("FAIL pause_pwm got %0d lit state %b exp 4 lit state 10", c, state);
        end
    endtask

    task automatic test_speed();
        stop_p = 1'b1; tick();
        for (int i = 0; i < 5; i++) begin fast_p = 1'b1; tick(); end
        tests_run++;
        if (speed !== 2'd3) begin tests_failed++; $display("FAIL speed_sat_hi got %0d exp 3", speed); end
        start_p = 1'b1; tick();
        for (int i = 0; i < 8; i++) tick();
        tests_run++;
        if (step !== 3'd1) begin tests_failed++; $display("FAIL speed3_frame1 got %0d exp 1", step); end
        for (int i = 0; i < 8; i++) tick();
        tests_run++;
        if (step !== 3'd2) begin tests_failed++; $display("FAIL speed3_frame2 got %0d exp 2", step); end
        for (int i = 0; i < 4; i++) begin slow_p = 1'b1; tick(); end
        tests_run++;
        if (speed !== 2'd0) begin tests_failed++; $display("FAIL speed_slow got %0d exp 0", speed); end
    endtask

    task automatic test_priority();
        stop_p = 1'b1; start_p = 1'b1; tick();
        tests_run++;
        if (state !== 2'b00 || step !== 3'd0) begin
            tests_failed++; $display("FAIL stop_over_start got state %b step %0d exp 00/0", state, step);
        end
        tick();
        tests_run++;
        if (led !== 4'b0000) begin tests_failed++; $display("FAIL idle_led got %b exp 0000", led); end
        next_p = 1'b1; tick();
        tests_run++;
        if (step !== 3'd0 || state !== 2'b00) begin
            tests_failed++; $display("FAIL next_in_idle got step %0d state %b exp 0/00", step, state);
        end
    endtask

    task automatic test_back_to_back();
        start_p = 1'b1; next_p = 1'b1; tick();
        tests_run++;
        if (state !== 2'b01 || step !== 3'd0) begin
            tests_failed++; $display("FAIL start_next_idle got state %b step %0d exp 01/0", state, step);
        end
        start_p = 1'b1; next_p = 1'b1; tick();
        tests_run++;
        if (state !== 2'b10 || step !== 3'd1) begin
            tests_failed++; $display("FAIL start_next_run got state %b step %0d exp 10/1", state, step);
        end
        fast_p = 1'b1; tick();
        fast_p = 1'b1; slow_p = 1'b1; tick();
        tests_run++;
        if (speed !== 2'd1) begin tests_failed++; $display("FAIL fast_slow_cancel got %0d exp 1", speed); end
    endtask

    task automatic test_async_reset();
        int c;
        start_p = 1'b1; tick();
        wr_en = 1'b1; wr_addr = 3'd0; wr_pat = 4'b1111; wr_lvl = 3'd2; tick();
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        tests_run++;
        if ({led, step, state, speed} !== 11'd0) begin
            tests_failed++; $display("FAIL async_reset got %b exp 0", {led, step, state, speed});
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
        start_p = 1'b1; tick();
        c = 0;
        for (int i = 0; i < 8; i++) begin tick(); if (led === 4'b0001) c++; end
        tests_run++;
        if (c != 8) begin tests_failed++; $display("FAIL table_reset got %0d exp 8", c); end
    endtask

    initial begin
        test_reset();
        test_start();
        test_duty();
        test_wrap_manual();
        test_speed();
        test_priority();
        test_back_to_back();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Bound on total run time so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL timeout at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/led_seq_ctrl.md
# led_seq_ctrl

Sequencing controller for the four-LED PWM brightness datapath on the lab board. It holds an 8-entry step table; each entry has an LED pattern and a brightness level. In run mode it advances through the table automatically at a button-selectable speed, and it generates the PWM gating for the user LEDs. Inputs are single-cycle pulses from the existing per-button debouncers; the output drives `usr_led` directly.

## Interface
- `PWM_PERIOD`, default 1000000: clocks per PWM frame; legal values ≥ 4 and divisible by 4.
- `DWELL_FRAMES`, default 50: PWM frames per step at speed 0; legal values ≥ 8.
- `clk`  in  1  system clock, 100 MHz.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `start_p`  in  1  pulse; start/pause toggle.
- `stop_p`  in  1  pulse; return to IDLE.
- `next_p` / `prev_p`  in  1  pulses; step forward/back.
- `fast_p` / `slow_p`  in  1  pulses; speed up/down.
- `wr_en`  in  1  table write strobe.
- `wr_addr`  in  3  table entry index.
- `wr_pat`  in  4  pattern to write.
- `wr_lvl`  in  3  brightness level to write (0..4).
- `led`  out  4  gated LED drive.
- `step`  out  3  current step index.
- `state`  out  2  00 IDLE, 01 RUN, 10 PAUSE.
- `speed`  out  2  current speed, 0..3.

## Operation
- **PWM counter** `pwm_cnt`:
  - Free-runs 0..PWM_PERIOD-1 in every state and wraps to 0.
  - A frame end is the cycle with `pwm_cnt == PWM_PERIOD-1`.
- **Duty:**
  - For level L the LEDs are on when `pwm_cnt < L*(PWM_PERIOD/4)`.
  - L=0 is always off; L=4 is always on.
  - A written `wr_lvl` greater than 4 is stored as 4.
- **LED output:**
  - Registered: `led <= (state != IDLE && on) ? tbl_pat[step] : 0`.
  - In PAUSE the PWM keeps running, so the held step stays lit.
- **Table reset contents** (entries 0..7):
  - Patterns: 0001, 0010, 0100, 1000, 1000, 0100, 0010, 0001.
  - Every level = 4.
- **Table writes:**
  - Accepted in any state.
  - The stored value is visible to the duty/pattern logic on the cycle after `wr_en`.
- **FSM transitions:**
  - IDLE --start_p--> RUN, with step=0 and dwell=0.
  - RUN --start_p--> PAUSE.
  - PAUSE --start_p--> RUN; the dwell count is retained.
  - Any state --stop_p--> IDLE, with step=0 and dwell=0.
- **Dwell:**
  - Dwell limit D = max(1, DWELL_FRAMES >> speed).
  - In RUN only, `dwell` increments at each frame end.
  - At the frame end where `dwell == D-1`: step ← step+1 (mod 8) and dwell ← 0.
- **Manual stepping:**
  - `next_p`/`prev_p` in RUN or PAUSE: step ± 1 (mod 8) and dwell ← 0.
  - Ignored in IDLE.
- **Speed:**
  - `fast_p` increments and `slow_p` decrements, saturating at 3 and 0.
  - Active in every state.
- **Simultaneous events**, resolved per cycle:
  - `stop_p` overrides `start_p`, `next_p` and `prev_p`.
  - `next_p` together with `prev_p` does nothing to step/dwell.
  - A manual step in the same cycle as an auto-advance is applied instead of the auto-advance: step moves once and dwell ← 0.
  - `fast_p` together with `slow_p`: no change.
  - `start_p` plus `next_p` from PAUSE/RUN: both take effect.
  - `start_p` plus `next_p` from IDLE: only the start takes effect.
- **Speed change mid-step:**
  - If `dwell ≥ new D-1`, advance at the next frame end.

## Timing
- All state is on `posedge clk` or async reset.
- **Reset values:**
  - `led`=0, `step`=0, `state`=00, `speed`=0.
  - `pwm_cnt`=0, `dwell`=0.
  - Table holds its reset contents.
- **Pulse latency:** one cycle. A pulse at edge N updates `state`/`step`/`speed` at edge N+1.
- **LED latency:** `led` reflects `pwm_cnt`, `step` and the table with one cycle of latency.
- **Reset mid-operation:** asserting `reset_n` low forces all reset values immediately, regardless of `clk`.
- **Input pulses:** assumed exactly one cycle wide. A held-high input repeats its action every cycle.

## Test plan
Run with PWM_PERIOD=8 and DWELL_FRAMES=8.
- **Reset and start:** release reset, then pulse `start_p`.
  - `state`=01 and `step`=0.
  - `led`=0001 for `pwm_cnt` 0..7, i.e. level 4 is fully on.
  - `step` becomes 1 after 8 frames (64 cycles).
- **Duty:** write entry 0 with `wr_lvl`=1, then run.
  - `led`=0001 for exactly 2 of every 8 cycles.
  - Write `wr_lvl`=7: it reads back as level 4, always on.
- **Wrap and manual step:**
  - In PAUSE at step 7, `next_p` gives step 0.
  - Then `prev_p` gives step 7.
  - `next_p` together with `prev_p` leaves the step unchanged.
  - In PAUSE, `led` keeps toggling with the PWM.
- **Speed:**
  - Pulse `fast_p` 5 times: `speed`=3 and D=1, so `step` advances every frame (8 cycles).
  - Pulse `slow_p` 4 times: `speed`=0.
- **Priority:**
  - `stop_p` together with `start_p` in RUN gives IDLE, `step`=0, and `led`=0 one cycle later.
  - `next_p` in IDLE is ignored.
- **Async reset:** drop `reset_n` mid-RUN between clock edges.
  - All outputs go to 0 immediately.
  - A table entry written before the reset reads back as its reset contents.
